imem_arbiter: RTL and testbench

Single-port instruction-memory controller between the IF stage and a program loader/debug port. Owns the one synchronous-read port of the instruction RAM and arbitrates fetch reads against loader reads and writes. Holds fetch off during a BOOT phase until software loading completes. Returns read data with fixed one-cycle latency.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_grant.sv | 44 ++++
 rtl/imem_arbiter.sv | 153 +++++++++++++++
 tb/tb_imem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory arbiter: FSM state encoding,
// requester IDs, default RAM depth, response bundle and an alignment helper.
package imem_pkg;

  localparam int DEFAULT_DEPTH = 1024;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LOAD  = 1'b1;

  typedef struct packed {
    logic pend;
    logic err;
    logic wr;
  } rsp_t;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/imem_grant.sv
// Pure grant selection for the instruction-memory port.
// Ports: state, f_req, l_req, starve (or last with IMEM_ARB_RR_EN) -> f_gnt, l_gnt.
module imem_grant
  import imem_pkg::*;
(
  input  logic [0:0] state,
  input  logic       f_req,
  input  logic       l_req,
`ifdef IMEM_ARB_RR_EN
  input  logic       last,
`else
  input  logic       starve,
`endif
  output logic       f_gnt,
  output logic       l_gnt
);

  logic load_wins;

`ifdef IMEM_ARB_RR_EN
  assign load_wins = (last == REQ_FETCH);
`else
  assign load_wins = starve;
`endif

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    unique case (1'b1)
      (state == ST_BOOT): begin
        l_gnt = l_req;
      end
      (state == ST_RUN && f_req && l_req): begin
        l_gnt = load_wins;
        f_gnt = !load_wins;
      end
      default: begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    endcase
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port IMEM controller: arbitrates fetch vs loader, 1-cycle responses.
// Ports: clk, rst (async low), boot_release/boot_done, f_*, l_*, m_*. Macro: IMEM_ARB_RR_EN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_release,
  output logic                     boot_done,
  input  logic                     f_req,
  input  logic [ADDR_W-1:0]        f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [DATA_W-1:0]        f_rdata,
  output logic                     f_err,
  input  logic                     l_req,
  input  logic                     l_we,
  input  logic [ADDR_W-1:0]        l_addr,
  input  logic [DATA_W-1:0]        l_wdata,
  output logic                     l_gnt,
  output logic                     l_rvalid,
  output logic [DATA_W-1:0]        l_rdata,
  output logic                     l_err,
  output logic                     m_en,
  output logic                     m_we,
  output logic [$clog2(DEPTH)-1:0] m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic [DATA_W-1:0]        m_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [0:0]    state;
  logic          f_rq;
  logic          l_rq;
  logic          f_mis;
  logic          l_mis;
  logic          f_acc;
  logic          l_acc;
  logic [AW-1:0] f_idx;
  logic [AW-1:0] l_idx;
  rsp_t          f_rsp;
  rsp_t          l_rsp;

  // Requests are masked while reset is held so every output sits at its
  // reset value even if a requester keeps driving.
  assign f_rq = f_req & rst;
  assign l_rq = l_req & rst;

  assign f_mis = misaligned(f_addr[1:0]);
  assign l_mis = misaligned(l_addr[1:0]);
  assign f_idx = f_addr[AW+1:2];
  assign l_idx = l_addr[AW+1:2];

`ifdef IMEM_ARB_RR_EN
  logic ptr;

  imem_grant u_grant (
    .state (state),
    .f_req (f_rq),
    .l_req (l_rq),
    .last  (ptr),
    .f_gnt (f_gnt),
    .l_gnt (l_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= REQ_FETCH;
    end else if (l_gnt) begin
      ptr <= REQ_LOAD;
    end else if (f_gnt) begin
      ptr <= REQ_FETCH;
    end
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;
  logic          starve;

  assign starve = (cnt == CMAX);

  imem_grant u_grant (
    .state  (state),
    .f_req  (f_rq),
    .l_req  (l_rq),
    .starve (starve),
    .f_gnt  (f_gnt),
    .l_gnt  (l_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (l_gnt) begin
      cnt <= '0;
    end else if (l_rq && !starve) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  // Misaligned requests are granted but never touch the RAM.
  assign f_acc   = f_gnt & !f_mis;
  assign l_acc   = l_gnt & !l_mis;
  assign m_en    = f_acc | l_acc;
  assign m_we    = l_acc & l_we;
  assign m_addr  = f_acc ? f_idx : (l_acc ? l_idx : '0);
  assign m_wdata = m_we ? l_wdata : '0;

  assign boot_done = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
    end else if (state == ST_BOOT && boot_release) begin
      state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_rsp <= '0;
      l_rsp <= '0;
    end else begin
      f_rsp <= '{pend: f_gnt, err: f_mis, wr: 1'b0};
      l_rsp <= '{pend: l_gnt, err: l_mis, wr: l_we};
    end
  end

  assign f_rvalid = f_rsp.pend;
  assign f_err    = f_rsp.pend & f_rsp.err;
  assign f_rdata  = (f_rsp.pend && !f_rsp.err) ? m_rdata : '0;

  assign l_rvalid = l_rsp.pend;
  assign l_err    = l_rsp.pend & l_rsp.err;
  assign l_rdata  = (l_rsp.pend && !l_rsp.err && !l_rsp.wr)
                    ? m_rdata : '0;

  // Upper address bits are ignored: addresses wrap modulo DEPTH words.
  logic unused;
  assign unused = ^{f_addr[ADDR_W-1:AW+2],
                    l_addr[ADDR_W-1:AW+2],
                    f_rsp.wr};

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus random
// traffic checked against a behavioural grant/memory model.
module tb_imem_arbiter;

  localparam int AW_B  = 32;
  localparam int DW    = 32;
  localparam int DEP   = 64;
  localparam int SMAX  = 8;
  localparam int IW    = $clog2(DEP);

  logic          clk;
  logic          rst;
  logic          boot_release;
  logic          boot_done;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;
  logic          m_en;
  logic          m_we;
  logic [IW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  imem_arbiter #(
    .ADDR_W(AW_B), .DATA_W(DW), .DEPTH(DEP), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .boot_release(boot_release), .boot_done(boot_done),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: synchronous read, one-cycle latency.
  logic [31:0] ram [DEP];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      else      m_rdata <= ram[m_addr];
    end
  end

  int n_vec;
  int n_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Behavioural reference state.
  bit          run;
  int          streak;
  bit          last_load;
  bit [31:0]   shadow [DEP];
  bit          fp, fe, lp, le;
  bit [31:0]   fd, ld;
  bit          last_fg, last_lg;

  task automatic model_reset();
    run = 0; streak = 0; last_load = 0;
    fp = 0; fe = 0; fd = 0;
    lp = 0; le = 0; ld = 0;
    last_fg = 0; last_lg = 0;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEP);
  endfunction

  task automatic drive(input bit fr, input logic [31:0] fa,
                       input bit lr, input bit lw,
                       input logic [31:0] la, input logic [31:0] lwd,
                       input bit br);
    f_req = fr; f_addr = fa;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd;
    boot_release = br;
  endtask

  task automatic tick();
    bit ef, el, fm, lm, ee, ew;
    int fi, li, ea;
    logic [31:0] ewd;
    @(negedge clk);
    ef = 0; el = 0;
    if (!run) begin
      el = l_req;
    end else if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
      el = !last_load;
`else
      el = (streak >= SMAX);
`endif
      ef = !el;
    end else begin
      ef = f_req; el = l_req;
    end
    fm = (f_addr % 4) != 0;
    lm = (l_addr % 4) != 0;
    fi = widx(f_addr);
    li = widx(l_addr);
    ee = (ef && !fm) || (el && !lm);
    ew = el && !lm && l_we;
    ea = (ef && !fm) ? fi : ((el && !lm) ? li : 0);
    ewd = ew ? l_wdata : 32'h0;
    chk("f_gnt", f_gnt, ef);
    chk("l_gnt", l_gnt, el);
    chk("m_en", m_en, ee);
    chk("m_we", m_we, ew);
    chk("m_addr", m_addr, ea);
    chk("m_wdata", m_wdata, ewd);
    chk("boot_done", boot_done, run);
    chk("f_rvalid", f_rvalid, fp);
    chk("f_err", f_err, fp && fe);
    chk("f_rdata", f_rdata, fd);
    chk("l_rvalid", l_rvalid, lp);
    chk("l_err", l_err, lp && le);
    chk("l_rdata", l_rdata, ld);
    fp = ef; fe = fm;
    fd = (ef && !fm) ? shadow[fi] : 32'h0;
    lp = el; le = lm;
    ld = (el && !lm && !l_we) ? shadow[li] : 32'h0;
    if (ew) shadow[li] = l_wdata;
    if (el) streak = 0;
    else if (l_req && streak < SMAX) streak++;
    if (el) last_load = 1;
    else if (ef) last_load = 0;
    if (!run && boot_release) run = 1;
    last_fg = ef; last_lg = el;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state();
    @(negedge clk);
    chk("rst_boot_done", boot_done, 1'b0);
    chk("rst_f_gnt", f_gnt, 1'b0);
    chk("rst_l_gnt", l_gnt, 1'b0);
    chk("rst_f_rvalid", f_rvalid, 1'b0);
    chk("rst_l_rvalid", l_rvalid, 1'b0);
    chk("rst_f_err", f_err, 1'b0);
    chk("rst_l_err", l_err, 1'b0);
    chk("rst_f_rdata", f_rdata, 32'h0);
    chk("rst_l_rdata", l_rdata, 32'h0);
    chk("rst_m_en", m_en, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  int first_l;
  bit prev_l;
  bit alt_ok;

  initial begin
    n_vec = 0; n_err = 0;
    for (int i = 0; i < DEP; i++) begin
      ram[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    m_rdata = 32'h0;
    model_reset();
    rst = 1'b0;
    // Requests held high during reset must not leak through.
    drive(1, 32'h0, 1, 1, 32'h0, 32'hdeadbeef, 0);
    chk_reset_state();
    @(posedge clk); #1;
    rst = 1'b1;

    // BOOT: loader writes, fetch is held off.
    drive(1, 32'h0, 1, 1, 32'h0, 32'h00500093, 0);
    tick();
    chk("boot_l_rvalid", l_rvalid, 1'b1);
    drive(1, 32'h0, 1, 1, 32'h4, 32'h001080b3, 0);
    tick();
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    tick();
    drive(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
    tick();
    chk("run_fetch_data", f_rdata, 32'h001080b3);

    // Contention with both held high.
    first_l = 0;
    alt_ok = 1;
    prev_l = 0;
    drive(1, 32'h0, 1, 0, 32'h4, 32'h0, 0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (last_lg && first_l == 0) first_l = c;
      if (c > 1 && last_lg == prev_l) alt_ok = 0;
      prev_l = last_lg;
    end
`ifdef IMEM_ARB_RR_EN
    chk("rr_alternate", alt_ok, 1'b1);
`else
    chk("starve_cycle", first_l, SMAX + 1);
`endif

    // Misaligned fetch and loader write, then address wrap.
    drive(1, 32'h6, 0, 0, 32'h0, 32'h0, 0);
    tick();
    chk("mis_f_err", f_err, 1'b1);
    chk("mis_f_rdata", f_rdata, 32'h0);
    drive(0, 32'h0, 1, 1, 32'h3, 32'h12345678, 0);
    tick();
    drive(1, 32'h104, 0, 0, 32'h0, 32'h0, 0);
    tick();
    chk("wrap_data", f_rdata, 32'h001080b3);

    // Reset asserted the cycle after a read grant.
    drive(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
    tick();
    rst = 1'b0;
    chk_reset_state();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();

    // Random traffic; denied requests are held unchanged.
    for (int c = 0; c < 600; c++) begin
      if (!(f_req && !last_fg)) begin
        f_req = ($urandom_range(3) != 0);
        f_addr = rnd_addr();
      end
      if (!(l_req && !last_lg)) begin
        l_req = ($urandom_range(2) == 0);
        l_we = $urandom_range(1);
        l_addr = rnd_addr();
        l_wdata = $urandom;
      end
      boot_release = ($urandom_range(31) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
